// File: rtl/dice_game_ctrl.sv
// Craps sequencing controller: gates the dice counters while rolling, latches the dice and scores each roll.
// Optional GAME_STATS_EN adds saturating win/loss totals that only rst clears.
module dice_game_ctrl #(
  parameter int ROLL_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  roll,
  input  logic [2:0]            dice1_in,
  input  logic [2:0]            dice2_in,
  output logic                  cnt_en,
  output logic [2:0]            dice1_out,
  output logic [2:0]            dice2_out,
  output logic [3:0]            sum_out,
  output logic [3:0]            point_out,
  output logic                  point_valid,
  output logic                  win,
  output logic                  lose,
  output logic [ROLL_CNT_W-1:0] roll_count,
  output logic                  err
`ifdef GAME_STATS_EN
  ,
  output logic [7:0]            wins_total,
  output logic [7:0]            losses_total
`endif
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ROLL = 3'd1,
    S_EVAL = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  function automatic logic [ROLL_CNT_W-1:0] sat_inc_cnt(input logic [ROLL_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic dice_illegal(input logic [2:0] d);
    return (d == 3'd0) || (d == 3'd7);
  endfunction

  state_t                  state_q, state_d;
  logic                    roll_q;
  logic                    rise, fall;
  logic                    capture;
  logic [2:0]              dice1_p0, dice2_p0;
  logic [3:0]              sum_p0;
  logic                    vld_p0;
  logic [3:0]              point_q, point_d;
  logic                    pv_q, pv_d;
  logic                    win_q, win_d;
  logic                    lose_q, lose_d;
  logic [ROLL_CNT_W-1:0]   cnt_q, cnt_d;
  logic                    err_q, err_d;

  assign rise   = roll & ~roll_q;
  assign fall   = ~roll & roll_q;
  assign sum_p0 = {1'b0, dice1_p0} + {1'b0, dice2_p0};
  assign vld_p0 = (state_q == S_EVAL);

  always_comb begin
    state_d = state_q;
    point_d = point_q;
    pv_d    = pv_q;
    win_d   = win_q;
    lose_d  = lose_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    capture = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (rise) begin
          // A fresh game: wipe the previous result before the first roll
          state_d = S_ROLL;
          point_d = 4'd0;
          pv_d    = 1'b0;
          win_d   = 1'b0;
          lose_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      S_ROLL: begin
        if (fall) begin
          capture = 1'b1;
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        if (dice_illegal(dice1_p0) || dice_illegal(dice2_p0)) begin
          err_d   = 1'b1;
          state_d = pv_q ? S_WAIT : S_IDLE;
        end else begin
          cnt_d = sat_inc_cnt(cnt_q);
          if (!pv_q) begin
            if (sum_p0 == 4'd7 || sum_p0 == 4'd11) begin
              win_d   = 1'b1;
              state_d = S_DONE;
            end else if (sum_p0 == 4'd2 || sum_p0 == 4'd3 || sum_p0 == 4'd12) begin
              lose_d  = 1'b1;
              state_d = S_DONE;
            end else begin
              point_d = sum_p0;
              pv_d    = 1'b1;
              state_d = S_WAIT;
            end
          end else begin
            if (sum_p0 == point_q) begin
              win_d   = 1'b1;
              state_d = S_DONE;
            end else if (sum_p0 == 4'd7) begin
              lose_d  = 1'b1;
              state_d = S_DONE;
            end else begin
              state_d = S_WAIT;
            end
          end
        end
      end
      S_WAIT: begin
        if (rise) state_d = S_ROLL;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stage p0: dice capture on release, scoring registered at the end of EVAL
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      roll_q   <= 1'b1;
      dice1_p0 <= 3'd0;
      dice2_p0 <= 3'd0;
      point_q  <= 4'd0;
      pv_q     <= 1'b0;
      win_q    <= 1'b0;
      lose_q   <= 1'b0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      roll_q  <= roll;
      if (capture) begin
        dice1_p0 <= dice1_in;
        dice2_p0 <= dice2_in;
      end
      point_q <= point_d;
      pv_q    <= pv_d;
      win_q   <= win_d;
      lose_q  <= lose_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

`ifdef GAME_STATS_EN
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (&v) ? v : v + 8'd1;
  endfunction

  logic [7:0] wins_q, losses_q;
  logic       enter_done;

  assign enter_done = vld_p0 && (state_d == S_DONE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      wins_q   <= 8'd0;
      losses_q <= 8'd0;
    end else if (enter_done) begin
      if (win_d)  wins_q   <= sat_inc8(wins_q);
      if (lose_d) losses_q <= sat_inc8(losses_q);
    end
  end

  assign wins_total   = wins_q;
  assign losses_total = losses_q;
`endif

  assign cnt_en      = (state_q == S_ROLL);
  assign dice1_out   = dice1_p0;
  assign dice2_out   = dice2_p0;
  assign sum_out     = sum_p0;
  assign point_out   = point_q;
  assign point_valid = pv_q;
  assign win         = win_q;
  assign lose        = lose_q;
  assign roll_count  = cnt_q;
  assign err         = err_q;

endmodule
